// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
// The optional skid entry is enabled by defining PIPE_STAGE_SKID_EN.
package pipe_pkg;

  // Occupancy states. The encoding equals the number of held entries, so occ is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipeState_t;

  // PC value restored by reset.
  localparam logic [31:0] PIPE_PC_RST = 32'h0000_3004;

  // Payload widths for each pipeline boundary. Each stage packs its own fields into these.
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_DATA_W  = 160;
  localparam int EX_MEM_DATA_W = 96;
  localparam int MEM_WB_DATA_W = 72;

  // Number of held entries for a given state.
  function automatic logic [1:0] occOf(input pipeState_t s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline register entry: a valid bit, an opaque payload, and a PC.
// Clearing empties the entry but keeps the PC, so the faulting PC survives a flush.
// Used by pipe_stage_reg; the skid copy exists only when PIPE_STAGE_SKID_EN is defined.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] PC_RST = PC_W'(PIPE_PC_RST)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] inData,
  input  logic [PC_W-1:0]   inPc,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [PC_W-1:0]   pc
);

  // Entry update. The priority is clear, then load, then drop. Clear keeps pc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= PC_RST;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= inData;
      pc    <= inPc;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with a valid/ready handshake, synchronous flush
// and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to get a second (skid) entry and a registered in_ready.
// Without it, the block holds a single entry and in_ready is combinational.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_EMPTY | nothing held; out_valid=0, out_pc keeps its last value
//   ST_ONE   | main entry holds the payload that drives the outputs
//   ST_FULL  | main and skid both hold payloads; in_ready=0 (skid build only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] PC_RST = PC_W'(PIPE_PC_RST),
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pipeState_t        state, nextState;
  logic              inXfer, outXfer;
  logic              mainLoad, mainDrop, mainValid;
  logic [DATA_W-1:0] mainInData, mainData;
  logic [PC_W-1:0]   mainInPc, mainPc;
  logic [CNT_W-1:0]  stallCnt;

`ifdef PIPE_STAGE_SKID_EN
  logic              skidLoad, skidDrop, skidValid, mainFromSkid, inReadyReg;
  logic [DATA_W-1:0] skidData;
  logic [PC_W-1:0]   skidPc;

  assign in_ready   = inReadyReg;
  assign mainInData = mainFromSkid ? skidData : in_data;
  assign mainInPc   = mainFromSkid ? skidPc : in_pc;
`else
  assign in_ready   = ~mainValid | out_ready;
  assign mainInData = in_data;
  assign mainInPc   = in_pc;
`endif

  assign inXfer    = in_valid & in_ready;
  assign outXfer   = mainValid & out_ready;
  assign out_valid = mainValid;
  assign out_data  = mainData;
  assign out_pc    = mainPc;
  assign occ       = occOf(state);
  assign stall_cnt = stallCnt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= nextState;
  end

  // Next state and entry controls. A flush overrides everything and empties both entries.
  always_comb begin
    nextState = state;
    mainLoad  = 1'b0;
    mainDrop  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skidLoad     = 1'b0;
    skidDrop     = 1'b0;
    mainFromSkid = 1'b0;
`endif
    if (flush) begin
      nextState = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (inXfer) begin
            mainLoad  = 1'b1;
            nextState = ST_ONE;
          end
        end
        ST_ONE: begin
`ifdef PIPE_STAGE_SKID_EN
          if (inXfer && outXfer) begin
            mainLoad = 1'b1;
          end else if (inXfer) begin
            skidLoad  = 1'b1;
            nextState = ST_FULL;
          end else if (outXfer) begin
            mainDrop  = 1'b1;
            nextState = ST_EMPTY;
          end
`else
          // With one entry, in_ready implies out_ready here, so an input always replaces the output.
          if (inXfer) begin
            mainLoad = 1'b1;
          end else if (outXfer) begin
            mainDrop  = 1'b1;
            nextState = ST_EMPTY;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (outXfer) begin
            mainFromSkid = 1'b1;
            mainLoad     = skidValid;
            mainDrop     = ~skidValid;
            skidDrop     = 1'b1;
            nextState    = skidValid ? ST_ONE : ST_EMPTY;
          end
        end
`endif
        default: nextState = ST_EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Register in_ready from the next state, so there is no combinational path from out_ready to in_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inReadyReg <= 1'b1;
    else       inReadyReg <= (nextState != ST_FULL);
  end
`endif

  // Count backpressure cycles and saturate at all ones. Only reset clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stallCnt <= '0;
    else if (mainValid && !out_ready && !(&stallCnt))
      stallCnt <= stallCnt + CNT_ONE;
  end

  pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W), .PC_RST(PC_RST)) uMain (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .load   (mainLoad),
    .drop   (mainDrop),
    .inData (mainInData),
    .inPc   (mainInPc),
    .valid  (mainValid),
    .data   (mainData),
    .pc     (mainPc)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_entry #(.DATA_W(DATA_W), .PC_W(PC_W), .PC_RST(PC_RST)) uSkid (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .load   (skidLoad),
    .drop   (skidDrop),
    .inData (in_data),
    .inPc   (in_pc),
    .valid  (skidValid),
    .data   (skidData),
    .pc     (skidPc)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard checks for pipe_stage_reg in the build selected by PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic [31:0] out_pc;
  logic [1:0]  occ;
  logic [15:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [95:0] sbQ[$];
  logic [95:0] expData;
  int nextTag;

`ifdef PIPE_STAGE_SKID_EN
  localparam int HELD_OCC = 2;
`else
  localparam int HELD_OCC = 1;
`endif

  pipe_stage_reg #(.DATA_W(96), .PC_W(32), .PC_RST(32'h0000_3004), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_pc    (out_pc),
    .occ       (occ),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_pc = '0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_pc", out_pc, 32'h3004);
    chk("rst_occ", occ, 0);
    chk("rst_stall", stall_cnt, 0);
    #1 reset = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // single push
    in_valid = 1'b1; in_data = 96'hA5; in_pc = 32'h3010; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("push_out_valid", out_valid, 1);
    chk("push_out_data", out_data, 96'hA5);
    chk("push_out_pc", out_pc, 32'h3010);
    chk("push_occ", occ, 1);
    chk("push_stall", stall_cnt, 0);

`ifdef PIPE_STAGE_SKID_EN
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'hB6; in_pc = 32'h3014;
    tick();
    in_valid = 1'b0;
    chk("bp_occ_full", occ, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_pc_held", out_pc, 32'h3010);
    chk("bp_data_held", out_data, 96'hA5);
    chk("bp_stall1", stall_cnt, 1);
    tick();
    chk("bp_pc_held2", out_pc, 32'h3010);
    chk("bp_stall2", stall_cnt, 2);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_pc", out_pc, 32'h3014);
    chk("bp_rel_data", out_data, 96'hB6);
    chk("bp_rel_occ", occ, 1);
    chk("bp_rel_stall", stall_cnt, 2);
    chk("bp_rel_in_ready", in_ready, 1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'hC7; in_pc = 32'h3018;
    tick();
    chk("refill_occ", occ, 2);
    flush = 1'b1; in_data = 96'hD8; in_pc = 32'h301C;
    tick();
`else
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'hB6; in_pc = 32'h3014;
    #1 chk("bp_in_ready", in_ready, 0);
    tick(); tick(); tick();
    chk("bp_data_held", out_data, 96'hA5);
    chk("bp_pc_held", out_pc, 32'h3010);
    chk("bp_occ", occ, 1);
    chk("bp_stall3", stall_cnt, 3);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_rel", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_rel_pc", out_pc, 32'h3014);
    chk("bp_rel_data", out_data, 96'hB6);
    chk("bp_rel_stall", stall_cnt, 3);
    flush = 1'b1; in_valid = 1'b1; in_data = 96'hC7; in_pc = 32'h3018; out_ready = 1'b0;
    tick();
`endif
    // flush with a simultaneous push: the push is dropped and the oldest PC is kept
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, 0);
    chk("flush_out_pc", out_pc, 32'h3014);
    chk("flush_occ", occ, 0);
    chk("flush_stall", stall_cnt, 4);
    #1 chk("flush_in_ready", in_ready, 1);

    // flush while empty keeps out_pc
    out_ready = 1'b1; in_valid = 1'b1; in_data = 96'hD8; in_pc = 32'h3020;
    tick();
    in_valid = 1'b0;
    chk("p3020_pc", out_pc, 32'h3020);
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_pc", out_pc, 32'h3020);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("eflush_pc", out_pc, 32'h3020);
    chk("eflush_valid", out_valid, 0);
    chk("eflush_data", out_data, 0);
    chk("eflush_stall", stall_cnt, 4);

    // async reset in the middle of a cycle while holding data
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'hE9; in_pc = 32'h3024;
    tick();
    in_data = 96'hF0; in_pc = 32'h3028;
    tick();
    in_valid = 1'b0;
    chk("held_occ", occ, HELD_OCC);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_pc", out_pc, 32'h3004);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_occ", occ, 0);
    chk("arst_data", out_data, 0);
    #2 reset = 1'b0;
    #1 chk("arst_in_ready", in_ready, 1);

    // back-to-back streaming
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 96'h1000 + 96'(i);
      in_pc = 32'h4000 + 32'(4 * i);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, 96'h1000 + 96'(i));
      chk("stream_pc", out_pc, 32'h4000 + 32'(4 * i));
    end
    in_valid = 1'b0;
    chk("stream_stall", stall_cnt, 0);
    tick();

    // random handshake against a FIFO scoreboard
    nextTag = 32'h500;
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data = 96'(nextTag);
      in_pc = 32'(nextTag);
      @(negedge clk);
      chk("rnd_occ", occ, 128'(sbQ.size()));
      chk("rnd_valid", out_valid, sbQ.size() != 0);
`ifdef PIPE_STAGE_SKID_EN
      chk("rnd_in_ready", in_ready, sbQ.size() != 2);
`else
      chk("rnd_in_ready", in_ready, (sbQ.size() == 0) || out_ready);
`endif
      if (out_valid && out_ready && sbQ.size() != 0) begin
        expData = sbQ.pop_front();
        chk("rnd_data", out_data, expData);
      end
      if (in_valid && in_ready) begin
        sbQ.push_back(in_data);
        nextTag++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && sbQ.size() != 0; c++) begin
      @(negedge clk);
      if (out_valid && sbQ.size() != 0) begin
        expData = sbQ.pop_front();
        chk("drain_data", out_data, expData);
      end
      tick();
    end
    chk("drain_empty", sbQ.size(), 0);
    #4 chk("drain_out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
